// File: rtl/hwpe_ctrl_seq_mult_radix.sv
// hwpe_ctrl_seq_mult_radix
// Sequential signed/unsigned multiplier retiring STEP bits of operand a per cycle.
// Operands are captured on accept as magnitudes plus a sign flag. The magnitude
// product is accumulated digit by digit, then negated once in FIX if required.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous soft clear, drops any in-flight operation
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE and not clearing)
//   a_i          operand a (multiplier, digit-scanned), AW bits
//   b_i          operand b (multiplicand), BW bits
//   signed_i     operands are two's complement when high, sampled with operands
//   out_valid_o  prod_o holds a finished result
//   out_ready_i  consumer takes the result
//   prod_o       product, AW+BW bits
//   busy_o       multiplication in progress (RUN or FIX)
module hwpe_ctrl_seq_mult_radix #(
    parameter int unsigned AW   = 8,
    parameter int unsigned BW   = 8,
    parameter int unsigned STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    input  logic             signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [AW+BW-1:0] prod_o,
    output logic             busy_o
);

    localparam int unsigned N  = (AW + STEP - 1) / STEP;
    localparam int unsigned PW = N * STEP;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = AW + BW;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [AW-1:0]   r_a_mag, w_a_mag_d;
    logic [BW-1:0]   r_b_mag, w_b_mag_d;
    logic            r_neg, w_neg_d;
    logic [RW-1:0]   r_acc, w_acc_d;
    logic [KW-1:0]   r_k, w_k_d;
    logic [RW-1:0]   r_prod, w_prod_d;

    logic            w_accept;
    logic [AW-1:0]   w_a_mag_in;
    logic [BW-1:0]   w_b_mag_in;
    logic            w_neg_in;
    logic [31:0]     w_shamt;
    logic [PW-1:0]   w_a_pad;
    logic [STEP-1:0] w_digit;
    logic [RW-1:0]   w_pp;
    logic            w_last;

    assign in_ready_o  = (r_state == StIdle) & ~clear_i;
    assign out_valid_o = (r_state == StDone);
    assign busy_o      = (r_state == StRun) | (r_state == StFix);
    assign prod_o      = r_prod;

    assign w_accept = in_valid_i & in_ready_o;

    // Negating the most negative value wraps to itself, which read as unsigned
    // is exactly the required magnitude 2^(W-1).
    assign w_a_mag_in = (signed_i & a_i[AW-1]) ? (~a_i + AW'(1)) : a_i;
    assign w_b_mag_in = (signed_i & b_i[BW-1]) ? (~b_i + BW'(1)) : b_i;
    assign w_neg_in   = signed_i & (a_i[AW-1] ^ b_i[BW-1]);

    // Digit k of the zero-padded magnitude, and its weighted partial product.
    // The magnitude product never exceeds RW bits, so truncation loses nothing.
    assign w_shamt = 32'(r_k) * STEP;
    assign w_a_pad = PW'(r_a_mag);
    assign w_digit = STEP'(w_a_pad >> w_shamt);
    assign w_pp    = (RW'(w_digit) * RW'(r_b_mag)) << w_shamt;
    assign w_last  = (r_k == KW'(N - 1));

    always_comb begin
        w_state_d = r_state;
        w_a_mag_d = r_a_mag;
        w_b_mag_d = r_b_mag;
        w_neg_d   = r_neg;
        w_acc_d   = r_acc;
        w_k_d     = r_k;
        w_prod_d  = r_prod;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_a_mag_d = w_a_mag_in;
                    w_b_mag_d = w_b_mag_in;
                    w_neg_d   = w_neg_in;
                    w_acc_d   = '0;
                    w_k_d     = '0;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_acc_d = r_acc + w_pp;
                if (w_last) begin
                    w_state_d = StFix;
                end else begin
                    w_k_d = r_k + KW'(1);
                end
            end
            StFix: begin
                w_prod_d  = r_neg ? (~r_acc + RW'(1)) : r_acc;
                w_state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (clear_i) begin
            w_state_d = StIdle;
            w_a_mag_d = '0;
            w_b_mag_d = '0;
            w_neg_d   = 1'b0;
            w_acc_d   = '0;
            w_k_d     = '0;
            w_prod_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_a_mag <= '0;
            r_b_mag <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_k     <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_d;
            r_a_mag <= w_a_mag_d;
            r_b_mag <= w_b_mag_d;
            r_neg   <= w_neg_d;
            r_acc   <= w_acc_d;
            r_k     <= w_k_d;
            r_prod  <= w_prod_d;
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_seq_mult_radix.sv
// Directed bench: one 8x8 radix-2 instance and one 7x5 radix-4 instance.
module tb_hwpe_ctrl_seq_mult_radix;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        clr;
    logic        sgn;
    logic        out_rdy;
    logic        cur;

    logic        iv8, rdy8, ov8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        iv7, rdy7, ov7, busy7;
    logic [6:0]  a7;
    logic [4:0]  b7;
    logic [11:0] prod7;

    logic        m_rdy, m_ov, m_busy;
    logic [15:0] m_prod;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign m_rdy  = cur ? rdy7  : rdy8;
    assign m_ov   = cur ? ov7   : ov8;
    assign m_busy = cur ? busy7 : busy8;
    assign m_prod = cur ? {4'b0, prod7} : prod8;

    hwpe_ctrl_seq_mult_radix #(.AW(8), .BW(8), .STEP(1)) u_dut8 (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clr),
        .in_valid_i  (iv8),
        .in_ready_o  (rdy8),
        .a_i         (a8),
        .b_i         (b8),
        .signed_i    (sgn),
        .out_valid_o (ov8),
        .out_ready_i (out_rdy),
        .prod_o      (prod8),
        .busy_o      (busy8)
    );

    hwpe_ctrl_seq_mult_radix #(.AW(7), .BW(5), .STEP(2)) u_dut7 (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .clear_i     (clr),
        .in_valid_i  (iv7),
        .in_ready_o  (rdy7),
        .a_i         (a7),
        .b_i         (b7),
        .signed_i    (sgn),
        .out_valid_o (ov7),
        .out_ready_i (out_rdy),
        .prod_o      (prod7),
        .busy_o      (busy7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands for one cycle, then scrambles them to prove capture.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        sgn = s;
        if (cur) begin
            a7 = a[6:0]; b7 = b[4:0]; iv7 = 1'b1;
        end else begin
            a8 = a; b8 = b; iv8 = 1'b1;
        end
        @(negedge clk);
        iv7 = 1'b0; iv8 = 1'b0;
        a8 = 8'hA5; b8 = 8'h5A; a7 = 7'h55; b7 = 5'h0A; sgn = ~s;
    endtask

    // Called at the first negedge after the accept edge.
    task automatic wait_result(input string tag, input int exp_lat);
        int cyc = 0;
        int bcnt = 0;
        while (!m_ov && cyc < 40) begin
            if (m_busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_lat", tag), 32'(cyc), 32'(exp_lat));
        chk($sformatf("%s_busy", tag), 32'(bcnt), 32'(exp_lat));
        chk($sformatf("%s_rdy_lo", tag), 32'(m_rdy), 32'd0);
    endtask

    task automatic take(input string tag);
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
        chk($sformatf("%s_rdy_after", tag), 32'(m_rdy), 32'd1);
        chk($sformatf("%s_ov_after", tag), 32'(m_ov), 32'd0);
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp, input int lat);
        issue(a, b, s);
        wait_result(tag, lat);
        chk($sformatf("%s_prod", tag), 32'(m_prod), 32'(exp));
        take(tag);
    endtask

    initial begin
        int bad;
        int cnt;
        rst_ni = 1'b0; clr = 1'b0; sgn = 1'b0; out_rdy = 1'b0; cur = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; iv7 = 1'b0; a7 = '0; b7 = '0;

        #1;
        chk("rst_rdy", 32'(rdy8), 32'd1);
        chk("rst_ov", 32'(ov8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_prod", 32'(prod8), 32'd0);
        chk("rst_prod7", 32'(prod7), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // 8x8, STEP=1
        run("u_ff", 8'd255, 8'd255, 1'b0, 16'hFE01, 9);
        run("u_zero", 8'd0, 8'd200, 1'b0, 16'h0000, 9);
        run("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080, 9);
        run("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000, 9);
        run("s_m1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF, 9);
        run("s_5xm3", 8'd5, 8'hFD, 1'b1, 16'hFFF1, 9);

        // 7x5, STEP=2 (a padded to 8 bits)
        cur = 1'b1;
        run("p_127x31", 8'h7F, 8'h1F, 1'b0, 16'h0F61, 5);
        run("p_m64xm16", 8'h40, 8'h10, 1'b1, 16'h0400, 5);
        cur = 1'b0;

        // Back-pressure in DONE
        issue(8'd6, 8'd7, 1'b0);
        wait_result("bp", 9);
        chk("bp_prod", 32'(m_prod), 32'd42);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            iv8 = i[0];
            a8 = 8'(i * 37);
            #1;
            if (m_prod !== 16'd42 || m_ov !== 1'b1 || m_rdy !== 1'b0) bad++;
        end
        iv8 = 1'b0;
        chk("bp_hold", 32'(bad), 32'd0);
        take("bp");
        run("bp_next", 8'd3, 8'd4, 1'b0, 16'd12, 9);

        // Clear at k=3
        issue(8'd200, 8'd100, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_rdy_forced", 32'(m_rdy), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr_idle_rdy", 32'(m_rdy), 32'd1);
        chk("clr_busy", 32'(m_busy), 32'd0);
        chk("clr_prod", 32'(m_prod), 32'd0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_ov) cnt++;
        end
        chk("clr_no_ov", 32'(cnt), 32'd0);

        // Clear together with in_valid in IDLE
        @(negedge clk);
        clr = 1'b1; iv8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        #1;
        chk("clr_iv_rdy", 32'(m_rdy), 32'd0);
        @(negedge clk);
        clr = 1'b0; iv8 = 1'b0;
        #1;
        chk("clr_iv_noacc", 32'(m_busy), 32'd0);
        run("clr_next", 8'd7, 8'd9, 1'b0, 16'd63, 9);

        // Async reset mid-RUN, between edges
        issue(8'd10, 8'd10, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_rdy", 32'(m_rdy), 32'd1);
        chk("arst_busy", 32'(m_busy), 32'd0);
        chk("arst_ov", 32'(m_ov), 32'd0);
        chk("arst_prod", 32'(m_prod), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        run("arst_next", 8'd10, 8'd10, 1'b0, 16'd100, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
